seq_mult_bus: RTL and testbench

- Parametrised, bus-fed sequential shift-add multiplier; the next generation of the team's 32-bit bus-loaded multiplier.
- Operands arrive BUS_W bits per cycle over a narrow bus. DATA_W iterations of add/shift produce a 2*DATA_W product, returned BUS_W bits per beat.
- Output path adds ready/valid backpressure.
- Sits between a byte-wide host bus and the arithmetic datapath.

---
 rtl/seq_mult_bus_if.sv | 12 +
 rtl/seq_mult_bus.sv | 117 +++++++++++
 tb/tb_seq_mult_bus.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_mult_bus_if.sv
// seq_mult_bus_if: operand-load and product-return bus for seq_mult_bus
interface seq_mult_bus_if #(parameter int BUS_W = 8);
    logic             start;
    logic             sgn;
    logic             out_ready;
    logic             rdy;
    logic             send_output;
    logic [BUS_W-1:0] M;
    logic [BUS_W-1:0] P;
    modport master (output start, sgn, out_ready, M, input rdy, send_output, P);
    modport slave  (input start, sgn, out_ready, M, output rdy, send_output, P);
endinterface

// File: rtl/seq_mult_bus.sv
// seq_mult_bus: bus-fed shift-add multiplier; defining SEQ_MULT_SIGNED_EN adds a signed radix-2 Booth mode
module seq_mult_bus #(
    parameter int DATA_W = 32,
    parameter int BUS_W  = 8
) (
    input logic           clk,
    input logic           rst_b,
    seq_mult_bus_if.slave bus
);
    localparam int BEATS = DATA_W / BUS_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int LW    = $clog2(2 * BEATS + 1);
    localparam logic [LW-1:0]    LB_LAST  = LW'(BEATS - 1);
    localparam logic [LW-1:0]    LQ_FIRST = LW'(BEATS);
    localparam logic [LW-1:0]    LQ_LAST  = LW'(2 * BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

    typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_Q, CALC, OUT} state_t;

    state_t            state, state_n;
    logic [DATA_W:0]   a, pre, a_n;
    logic [DATA_W-1:0] b, q, q_n;
    logic [CNT_W-1:0]  cnt;
    logic [LW-1:0]     ld;
    logic              fill;
`ifdef SEQ_MULT_SIGNED_EN
    logic              sgn_r, q_m1;
    logic [DATA_W:0]   bx;
    logic              add_en;
`else
    logic              unused_sgn;
    assign unused_sgn = bus.sgn;
`endif

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = bus.start ? (BEATS == 1 ? LOAD_Q : LOAD_B) : IDLE;
            LOAD_B:  state_n = (ld == LB_LAST) ? LOAD_Q : LOAD_B;
            LOAD_Q:  state_n = (ld == LQ_LAST) ? CALC : LOAD_Q;
            CALC:    state_n = (cnt == CNT_DONE) ? OUT : CALC;
            OUT:     state_n = (bus.out_ready && ld == LQ_LAST) ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.rdy         = state == IDLE;
        bus.send_output = state == OUT;
        bus.P           = (state == OUT) ? q[BUS_W-1:0] : '0;
    end

    always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
        bx     = sgn_r ? {b[DATA_W-1], b} : {1'b0, b};
        add_en = sgn_r ? (q[0] ^ q_m1) : q[0];
        pre    = !add_en ? a : (sgn_r && q[0]) ? a - bx : a + bx;
        fill   = sgn_r & pre[DATA_W];
`else
        pre    = q[0] ? a + {1'b0, b} : a;
        fill   = 1'b0;
`endif
        a_n    = {fill, pre[DATA_W:1]};
        q_n    = {pre[0], q[DATA_W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            a   <= '0;
            b   <= '0;
            q   <= '0;
            cnt <= '0;
            ld  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn_r <= 1'b0;
            q_m1  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    b[BUS_W-1:0] <= bus.M;
                    ld           <= LW'(1);
`ifdef SEQ_MULT_SIGNED_EN
                    sgn_r        <= bus.sgn;
`endif
                end
                LOAD_B, LOAD_Q: begin
                    if (ld < LQ_FIRST) b[int'(ld) * BUS_W +: BUS_W] <= bus.M;
                    else               q[(int'(ld) - BEATS) * BUS_W +: BUS_W] <= bus.M;
                    ld  <= ld + LW'(1);
                    a   <= '0;
                    cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                    q_m1 <= 1'b0;
`endif
                end
                CALC: if (cnt == CNT_DONE) ld <= '0;
                else begin
                    a   <= a_n;
                    q   <= q_n;
                    cnt <= cnt + CNT_W'(1);
`ifdef SEQ_MULT_SIGNED_EN
                    q_m1 <= q[0];
`endif
                end
                OUT: if (bus.out_ready) begin
                    {a, q} <= {a, q} >> BUS_W;
                    ld     <= ld + LW'(1);
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_seq_mult_bus.sv
// tb_seq_mult_bus: directed-vector bench for seq_mult_bus at DATA_W=32, BUS_W=8
module tb_seq_mult_bus;
    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    seq_mult_bus_if #(.BUS_W(8)) bus ();
    seq_mult_bus #(.DATA_W(32), .BUS_W(8)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] b, input logic [31:0] qv, input logic s,
                          input int stall_at, input int start_at, input logic [63:0] exp,
                          output logic [63:0] prod, output int first, output int done_n);
        int n, k, held, w;
        prod  = '0;
        first = -1;
        k     = 0;
        held  = 0;
        w     = 0;
        while (!bus.rdy && w < 100) begin
            tick();
            w++;
        end
        check("rdy_before_start", 64'(bus.rdy), 64'd1);
        bus.start = 1'b1;
        bus.sgn   = s;
        bus.M     = b[7:0];
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            bus.M = (i < 4) ? b[i*8 +: 8] : qv[(i-4)*8 +: 8];
            tick();
        end
        n = 7;
        for (int c = 0; c < 300 && k < 8; c++) begin
            bus.start = (n == start_at);
            if (n == start_at) check("rdy_in_calc", 64'(bus.rdy), 64'd0);
            if (bus.send_output) begin
                if (first < 0) first = n;
                if (k == stall_at && held < 5) begin
                    bus.out_ready = 1'b0;
                    check("hold_p", 64'(bus.P), 64'(exp[k*8 +: 8]));
                    held++;
                end else begin
                    bus.out_ready = 1'b1;
                    prod[k*8 +: 8] = bus.P;
                    k++;
                end
            end
            tick();
            n++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        check("beats_done", 64'(k), 64'd8);
        done_n = n;
    endtask

    logic [63:0] prod;
    int          first, done_n;

    initial begin
        bus.start     = 1'b0;
        bus.sgn       = 1'b0;
        bus.out_ready = 1'b1;
        bus.M         = '0;
        #2 rst_b = 1'b0;
        #1;
        check("rst_rdy", 64'(bus.rdy), 64'd1);
        check("rst_valid", 64'(bus.send_output), 64'd0);
        check("rst_p", 64'(bus.P), 64'd0);
        @(negedge clk) rst_b = 1'b1;
        tick();

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1, 64'd0, prod, first, done_n);
        check("max_prod", prod, 64'hFFFFFFFE_00000001);
        check("max_first", 64'(first), 64'd40);
        check("max_rdy_at", 64'(done_n), 64'd48);
        check("max_rdy", 64'(bus.rdy), 64'd1);
        check("max_p_idle", 64'(bus.P), 64'd0);
        check("max_valid_idle", 64'(bus.send_output), 64'd0);

        run_op(32'd3, 32'd5, 1'b0, -1, -1, 64'd0, prod, first, done_n);
        check("3x5_prod", prod, 64'h0000000F);
        check("3x5_first", 64'(first), 64'd40);

        run_op(32'h12345678, 32'd1, 1'b0, -1, -1, 64'd0, prod, first, done_n);
        check("x1_prod", prod, 64'h12345678);

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, -1, 64'hFFFFFFFE_00000001, prod, first, done_n);
        check("bp_prod", prod, 64'hFFFFFFFE_00000001);
        check("bp_rdy_at", 64'(done_n), 64'd53);

        run_op(32'hDEADBEEF, 32'h00000100, 1'b0, -1, 20, 64'd0, prod, first, done_n);
        check("start_calc_prod", prod, 64'h000000DE_ADBEEF00);
        check("start_calc_rdy_at", 64'(done_n), 64'd48);

        bus.start = 1'b1;
        bus.M     = 8'h11;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        rst_b = 1'b0;
        #1;
        check("mid_rst_rdy", 64'(bus.rdy), 64'd1);
        check("mid_rst_valid", 64'(bus.send_output), 64'd0);
        check("mid_rst_p", 64'(bus.P), 64'd0);
        @(negedge clk) rst_b = 1'b1;
        tick();
        run_op(32'd7, 32'd9, 1'b0, -1, -1, 64'd0, prod, first, done_n);
        check("post_rst_prod", prod, 64'd63);

        run_op(32'hFFFFFFFE, 32'd3, 1'b1, -1, -1, 64'd0, prod, first, done_n);
`ifdef SEQ_MULT_SIGNED_EN
        check("sgn_neg2x3", prod, 64'hFFFFFFFF_FFFFFFFA);
`else
        check("sgn_neg2x3", prod, 64'h00000002_FFFFFFFA);
`endif
        run_op(32'h80000000, 32'h80000000, 1'b1, -1, -1, 64'd0, prod, first, done_n);
        check("sgn_minxmin", prod, 64'h40000000_00000000);
        run_op(32'hFFFFFFFE, 32'd3, 1'b0, -1, -1, 64'd0, prod, first, done_n);
        check("uns_neg2x3", prod, 64'h00000002_FFFFFFFA);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
